reveal_readout_seq: RTL
=======================

Name: reveal_readout_seq

Overview:
Frame readout sequencer for the Reveal imager. On a start pulse it walks rows 0..N_ROWS-1. For each row it reads the left bucket, then the right bucket, through the PGA/sample/ADC-mux chain, then resets that row's buckets. It drives the imager readout pins (ROW_ADD, COL_L_EN, PIXRES_L/R, STDBY, PRECH_COL, PGA_RES, CK_PH1, SAMP_S/R, READ_R/S, MUX_START, CP_COLMUX_IN). It sits beside the pattern-stream block under the imager top level; DRAIN and PIXGLOB_RES are owned by the exposure controller, not this block.

Parameters:
N_ROWS, 244, rows per frame (1..256)
N_COLMUX, 20, column-mux levels per bucket (>=1)
T_PRECH, 4, PRECH_COL high cycles; also PIXRES high cycles
T_SAMP, 8, SAMP_R / SAMP_S high cycles
N_PUMP, 4, CK_PH1 pulses per bucket (1 cycle high, 1 cycle low each)
T_READ, 4, READ_R and READ_S high cycles each

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle pulse; begins a frame when idle
abort  in  1  synchronous; terminates frame
adc_ready  in  1  1-cycle pulse from ADC: current mux level converted
busy  out  1  high from the cycle after an accepted start until return to IDLE
frame_done  out  1  1-cycle pulse when the last row completes
ROW_ADD  out  8  current row
COL_L_EN  out  1  1 = left bucket, 0 = right
PIXRES_L, PIXRES_R  out  1 each  row bucket reset
STDBY  out  1  high when not reading out
PRECH_COL, PGA_RES, CK_PH1, SAMP_S, SAMP_R, READ_R, READ_S, MUX_START, CP_COLMUX_IN  out  1 each  readout strobes

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All outputs are registered and are a function of the state, with no combinational path from any input.
- Reset values: STDBY=1, COL_L_EN=1, ROW_ADD=0, busy=0, frame_done=0, all other strobes 0. State=IDLE, row=0, bucket=L.
- States and per-state outputs, in order for each row/bucket:
  - PRECH: T_PRECH cycles, PRECH_COL=1.
  - SAMPR: T_SAMP cycles, PGA_RES=1, SAMP_R=1.
  - PUMP: 2*N_PUMP cycles; CK_PH1=1 on even cycle offsets, 0 on odd.
  - SAMPS: T_SAMP cycles, SAMP_S=1.
  - MSTART: 1 cycle, MUX_START=1.
  - RDR: T_READ cycles, READ_R=1.
  - RDS: T_READ cycles, READ_S=1.
  - WADC: hold all strobes 0 until adc_ready.
    - If this is not the last mux level: go to STEP.
    - Else if bucket=L: set bucket=R, go to PRECH.
    - Else: go to ROWRES.
  - STEP: 1 cycle, CP_COLMUX_IN=1, level++, go to RDR.
  - ROWRES: T_PRECH cycles, PIXRES_L=PIXRES_R=1. Then:
    - if row<N_ROWS-1: row++, bucket=L, go to PRECH;
    - else go to IDLE with frame_done=1 for one cycle.
- IDLE: STDBY=1. STDBY=0 in every other state.
- ROW_ADD and COL_L_EN are updated on entry to PRECH and are stable for the whole row/bucket.
- Mux level counter resets to 0 on entry to PRECH. CP_COLMUX_IN is never issued after the last level.
- Start: IDLE + start -> PRECH next cycle, row=0, bucket=L. start while busy is ignored.
- Abort: any state + abort -> IDLE next cycle; outputs return to reset values; no frame_done. Abort has priority over start in the same cycle.
- adc_ready outside WADC is ignored and is not remembered.
- No timeout in WADC.
- Row wraps only via IDLE; ROW_ADD returns to 0 in IDLE.
- Cycles per bucket, excluding ADC wait: T_PRECH + 2*T_SAMP + 2*N_PUMP + 1 + N_COLMUX*(2*T_READ+1) - 1 + the WADC cycles.

Decomposition:
- Shared package reveal_pkg:
  - state enum (IDLE, PRECH, SAMPR, PUMP, SAMPS, MSTART, RDR, RDS, WADC, STEP, ROWRES);
  - ROW_W=8;
  - bucket encoding L=1/R=0.
- One sub-module, reveal_phase_timer: loadable down-counter with a load value and a done flag. The FSM loads it on each state entry.

Test Plan:
- Reset mid-frame (rst during PUMP of row 3) -> next edge shows STDBY=1, ROW_ADD=0, CK_PH1=0, busy=0.
- N_ROWS=2, N_COLMUX=3, adc_ready 2 cycles after each WADC entry, one start pulse -> on each row/bucket: PRECH_COL high exactly 4 cycles, 4 CK_PH1 pulses, 1 MUX_START, 2 CP_COLMUX_IN.
  - Sequence is (row0,L),(row0,R),(row1,L),(row1,R).
  - PIXRES_L/R high 4 cycles after each R bucket.
  - frame_done pulses once, then STDBY=1.
- adc_ready withheld 100 cycles in WADC -> all strobes stay 0, state held; adc_ready pulsed during RDR -> ignored, WADC still waits.
- start pulsed while busy -> no restart, ROW_ADD continues incrementing.
- abort asserted in STEP of row 1 -> IDLE next cycle, CP_COLMUX_IN drops, no frame_done. abort and start in the same IDLE cycle -> stays IDLE.
- N_ROWS=1, N_COLMUX=1 -> zero CP_COLMUX_IN pulses. The cycle count start-to-frame_done equals the formula plus the ADC wait cycles.

Source files
------------

// File: rtl/reveal_pkg.sv
// Shared types and helpers for the Reveal frame readout sequencer.
package reveal_pkg;

    localparam int unsigned ROW_W = 8;
    localparam int unsigned TMR_W = 16;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRECH,
        S_SAMPR,
        S_PUMP,
        S_SAMPS,
        S_MSTART,
        S_RDR,
        S_RDS,
        S_WADC,
        S_STEP,
        S_ROWRES
    } state_e;

    typedef enum logic {
        BKT_R = 1'b0,
        BKT_L = 1'b1
    } bucket_e;

    // Readout strobes driven to the imager (row/bucket select carried separately)
    typedef struct packed {
        logic stdby;
        logic pixres_l;
        logic pixres_r;
        logic prech_col;
        logic pga_res;
        logic ck_ph1;
        logic samp_s;
        logic samp_r;
        logic read_r;
        logic read_s;
        logic mux_start;
        logic cp_colmux_in;
    } pins_t;

    localparam pins_t PINS_IDLE = '{stdby: 1'b1, default: 1'b0};

    // Phase timer load value (cycles in state minus one) for a timed state
    function automatic logic [TMR_W-1:0] phase_load(
        input state_e      s,
        input int unsigned t_prech,
        input int unsigned t_samp,
        input int unsigned n_pump,
        input int unsigned t_read
    );
        int unsigned len;
        len = 1;
        case (s)
            S_PRECH, S_ROWRES: len = t_prech;
            S_SAMPR, S_SAMPS:  len = t_samp;
            S_PUMP:            len = 2 * n_pump;
            S_RDR, S_RDS:      len = t_read;
            default:           len = 1;
        endcase
        return TMR_W'(len - 32'd1);
    endfunction

endpackage

// File: rtl/reveal_phase_timer.sv
// Loadable down-counter timing each sequencer phase; done marks the last cycle.
module reveal_phase_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Reload on phase entry, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_c = (cnt_q == '0);

endmodule

// File: rtl/reveal_readout_seq.sv
// Reveal frame readout sequencer: walks rows, reads L then R bucket, resets row.
module reveal_readout_seq
    import reveal_pkg::*;
#(
    parameter int unsigned N_ROWS   = 244,
    parameter int unsigned N_COLMUX = 20,
    parameter int unsigned T_PRECH  = 4,
    parameter int unsigned T_SAMP   = 8,
    parameter int unsigned N_PUMP   = 4,
    parameter int unsigned T_READ   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             adc_ready,
    output logic             busy,
    output logic             frame_done,
    output logic [ROW_W-1:0] ROW_ADD,
    output logic             COL_L_EN,
    output logic             PIXRES_L,
    output logic             PIXRES_R,
    output logic             STDBY,
    output logic             PRECH_COL,
    output logic             PGA_RES,
    output logic             CK_PH1,
    output logic             SAMP_S,
    output logic             SAMP_R,
    output logic             READ_R,
    output logic             READ_S,
    output logic             MUX_START,
    output logic             CP_COLMUX_IN
);

    localparam int unsigned      LVL_W    = (N_COLMUX > 1) ? $clog2(N_COLMUX) : 1;
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(N_COLMUX - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(N_ROWS - 1);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    bucket_e            bkt_q, bkt_d;
    logic [LVL_W-1:0]   lvl_q, lvl_d;
    pins_t              pins_q, pins_d;
    logic               busy_q, busy_d;
    logic               frame_done_q, frame_done_d;
    logic               tmr_load_c;
    logic [TMR_W-1:0]   tmr_val_c;
    logic               tmr_done_c;

    reveal_phase_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done_c   (tmr_done_c)
    );

    // Next state, row/bucket/level bookkeeping; abort wins over everything
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        bkt_d        = bkt_q;
        lvl_d        = lvl_q;
        frame_done_d = 1'b0;
        if (abort) begin
            state_d = S_IDLE;
            row_d   = '0;
            bkt_d   = BKT_L;
            lvl_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_PRECH;
                        row_d   = '0;
                        bkt_d   = BKT_L;
                        lvl_d   = '0;
                    end
                end
                S_PRECH:  if (tmr_done_c) state_d = S_SAMPR;
                S_SAMPR:  if (tmr_done_c) state_d = S_PUMP;
                S_PUMP:   if (tmr_done_c) state_d = S_SAMPS;
                S_SAMPS:  if (tmr_done_c) state_d = S_MSTART;
                S_MSTART: state_d = S_RDR;
                S_RDR:    if (tmr_done_c) state_d = S_RDS;
                S_RDS:    if (tmr_done_c) state_d = S_WADC;
                S_WADC: begin
                    if (adc_ready) begin
                        if (lvl_q != LVL_LAST) begin
                            state_d = S_STEP;
                        end else if (bkt_q == BKT_L) begin
                            state_d = S_PRECH;
                            bkt_d   = BKT_R;
                            lvl_d   = '0;
                        end else begin
                            state_d = S_ROWRES;
                        end
                    end
                end
                S_STEP: begin
                    state_d = S_RDR;
                    lvl_d   = lvl_q + LVL_W'(1);
                end
                S_ROWRES: begin
                    if (tmr_done_c) begin
                        if (row_q != ROW_LAST) begin
                            state_d = S_PRECH;
                            row_d   = row_q + ROW_W'(1);
                            bkt_d   = BKT_L;
                            lvl_d   = '0;
                        end else begin
                            state_d      = S_IDLE;
                            row_d        = '0;
                            bkt_d        = BKT_L;
                            lvl_d        = '0;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Strobes for the upcoming state, plus timer reload on every state change
    always_comb begin
        pins_d       = '0;
        pins_d.stdby = (state_d == S_IDLE);
        case (state_d)
            S_PRECH:  pins_d.prech_col = 1'b1;
            S_SAMPR: begin
                pins_d.pga_res = 1'b1;
                pins_d.samp_r  = 1'b1;
            end
            S_PUMP:   pins_d.ck_ph1 = (state_q != S_PUMP) || !pins_q.ck_ph1;
            S_SAMPS:  pins_d.samp_s = 1'b1;
            S_MSTART: pins_d.mux_start = 1'b1;
            S_RDR:    pins_d.read_r = 1'b1;
            S_RDS:    pins_d.read_s = 1'b1;
            S_STEP:   pins_d.cp_colmux_in = 1'b1;
            S_ROWRES: begin
                pins_d.pixres_l = 1'b1;
                pins_d.pixres_r = 1'b1;
            end
            default: ;
        endcase
        busy_d     = (state_d != S_IDLE);
        tmr_load_c = (state_d != state_q);
        tmr_val_c  = phase_load(state_d, T_PRECH, T_SAMP, N_PUMP, T_READ);
    end

    // Sequencer state and registered pin outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            row_q        <= '0;
            bkt_q        <= BKT_L;
            lvl_q        <= '0;
            pins_q       <= PINS_IDLE;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            bkt_q        <= bkt_d;
            lvl_q        <= lvl_d;
            pins_q       <= pins_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy         = busy_q;
    assign frame_done   = frame_done_q;
    assign ROW_ADD      = row_q;
    assign COL_L_EN     = (bkt_q == BKT_L);
    assign PIXRES_L     = pins_q.pixres_l;
    assign PIXRES_R     = pins_q.pixres_r;
    assign STDBY        = pins_q.stdby;
    assign PRECH_COL    = pins_q.prech_col;
    assign PGA_RES      = pins_q.pga_res;
    assign CK_PH1       = pins_q.ck_ph1;
    assign SAMP_S       = pins_q.samp_s;
    assign SAMP_R       = pins_q.samp_r;
    assign READ_R       = pins_q.read_r;
    assign READ_S       = pins_q.read_s;
    assign MUX_START    = pins_q.mux_start;
    assign CP_COLMUX_IN = pins_q.cp_colmux_in;

endmodule
